// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// PcSequencer (module pc_sequencer)
//
// Purpose:
//   Controls the instruction-fetch program counter.
//   Each cycle it computes the next-PC value and drives the PC register's
//   next-address input, so the PC register itself needs no enable or reset.
//
//   Execution is sequenced through four modes under debug-unit control:
//   idle, continuous run, single step and halted.
//
//   It selects between the sequential (+4), branch and jump targets. It also
//   honours hazard stalls. A redirect that arrives while fetch is held is
//   parked until the PC can actually move.
//
// Parameters:
//   B          - address width
//   RESET_ADDR - address loaded into the PC while reset is asserted
//
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  synchronous, active-high reset
//   pc_current     in   B  current PC register output
//   branch_taken   in   1  branch redirect request this cycle
//   branch_target  in   B  branch destination
//   jump_taken     in   1  jump redirect request this cycle
//   jump_target    in   B  jump destination
//   stall          in   1  hazard unit: hold fetch this cycle
//   halt_detected  in   1  decode saw a halt instruction
//   run_cmd        in   1  debug unit: enter continuous run (pulse)
//   step_cmd       in   1  debug unit: execute one fetch (pulse)
//   next_pc        out  B  next-address input of the PC register (comb)
//   fetch_en       out  1  PC advances on this edge
//   flush_if_id    out  1  redirect applied this cycle, squash IF/ID
//   state          out  2  IDLE=00, RUN=01, STEP=10, HALTED=11
//   cycle_count    out 32  number of advances since reset
// ---------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned     B          = 32,
  parameter logic [B-1:0]    RESET_ADDR = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] pc_current,
  input  logic         branch_taken,
  input  logic [B-1:0] branch_target,
  input  logic         jump_taken,
  input  logic [B-1:0] jump_target,
  input  logic         stall,
  input  logic         halt_detected,
  input  logic         run_cmd,
  input  logic         step_cmd,
  output logic [B-1:0] next_pc,
  output logic         fetch_en,
  output logic         flush_if_id,
  output logic [1:0]   state,
  output logic [31:0]  cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } seq_state_t;

  seq_state_t   state_q;
  seq_state_t   state_d;
  logic         advance;
  logic         redirect_now;
  logic [B-1:0] target_now;
  logic         pending_valid;
  logic [B-1:0] pending_target;
  logic [31:0]  count_q;

  // Decide whether the PC moves this cycle.
  // It only moves in RUN or STEP with no hazard stall. In RUN, a halt seen by
  // decode stops the fetch on that very cycle, so the halt instruction is the
  // last one fetched. In STEP the halt indication is deliberately ignored.
  always_comb begin
    advance = 1'b0;
    if ((state_q == RUN || state_q == STEP) && !stall) begin
      advance = !(state_q == RUN && halt_detected);
    end
  end

  // Pick the redirect for this cycle.
  // The branch belongs to the older instruction in the pipe, so it wins when
  // both a branch and a jump are requested together.
  always_comb begin
    redirect_now = branch_taken || jump_taken;
    target_now   = branch_taken ? branch_target : jump_target;
  end

  // Next-PC select.
  // Reset has the highest priority, so the PC register loads RESET_ADDR on
  // the same edge. A held fetch feeds the current value straight back, which
  // is what lets the PC register go without an enable. A live redirect
  // outranks a parked one, because the live one comes from a younger
  // resolution of control flow.
  always_comb begin
    next_pc = pc_current + B'(4);
    if (reset) begin
      next_pc = RESET_ADDR;
    end else if (!advance) begin
      next_pc = pc_current;
    end else if (redirect_now) begin
      next_pc = target_now;
    end else if (pending_valid) begin
      next_pc = pending_target;
    end
  end

  // Drive the handshake outputs.
  // Both are forced low while reset is held. This keeps the rest of the
  // pipeline quiet even though the FSM register still shows the pre-reset
  // state during that cycle.
  always_comb begin
    fetch_en    = advance && !reset;
    flush_if_id = advance && !reset && (redirect_now || pending_valid);
  end

  // Parked redirect.
  // A redirect that cannot be applied because fetch is held is remembered
  // here. A newer one simply overwrites it. The first cycle that advances
  // consumes it, whether or not a fresh redirect took precedence on that
  // cycle. This guarantees exactly one flush per applied redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid  <= 1'b0;
      pending_target <= '0;
    end else if (redirect_now && !advance) begin
      pending_valid  <= 1'b1;
      pending_target <= target_now;
    end else if (advance) begin
      pending_valid  <= 1'b0;
    end
  end

  // FSM next-state logic.
  // In IDLE, step beats run if both commands arrive together. RUN and HALTED
  // ignore debug commands. STEP returns to IDLE on the single cycle that
  // actually advances, so stalls stretch the step without losing it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (step_cmd) begin
          state_d = STEP;
        end else if (run_cmd) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (halt_detected) begin
          state_d = HALTED;
        end
      end
      STEP: begin
        if (advance) begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  // Reset is the only way out of HALTED.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Advance counter.
  // Counts every edge on which the PC moves, and wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (advance) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign state       = state_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for pc_sequencer.
//
// Models the PC register as a plain flop fed by next_pc. It also provides a
// debugger-style load port, used to place the PC at interesting addresses.
// Directed vectors are checked against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_current;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        stall;
  logic        halt_detected;
  logic        run_cmd;
  logic        step_cmd;
  logic [31:0] next_pc;
  logic        fetch_en;
  logic        flush_if_id;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  logic        pc_load;
  logic [31:0] pc_load_val;

  int vectors;
  int miscompares;

  pc_sequencer #(.B(32), .RESET_ADDR(32'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_current    (pc_current),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump_taken    (jump_taken),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt_detected (halt_detected),
    .run_cmd       (run_cmd),
    .step_cmd      (step_cmd),
    .next_pc       (next_pc),
    .fetch_en      (fetch_en),
    .flush_if_id   (flush_if_id),
    .state         (state),
    .cycle_count   (cycle_count)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register model.
  // It loads next_pc every edge unless the bench forces an address in.
  always_ff @(posedge clk) begin
    if (pc_load) begin
      pc_current <= pc_load_val;
    end else begin
      pc_current <= next_pc;
    end
  end

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive all control inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic bt, input logic [31:0] btgt,
                               input logic jt, input logic [31:0] jtgt,
                               input logic stl, input logic hlt,
                               input logic run, input logic stp);
    branch_taken  = bt;
    branch_target = btgt;
    jump_taken    = jt;
    jump_target   = jtgt;
    stall         = stl;
    halt_detected = hlt;
    run_cmd       = run;
    step_cmd      = stp;
    #1;
  endtask

  task automatic quiet();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Force the PC register to an address, holding fetch with stall meanwhile.
  task automatic loadPc(input logic [31:0] addr);
    pc_load     = 1'b1;
    pc_load_val = addr;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pc_load     = 1'b0;
    pc_load_val = 32'h0;
    reset       = 1'b1;
    quiet();

    // Reset for two cycles, then run four free cycles.
    checkOutput("rst_next_pc", next_pc, 32'h0);
    checkOutput("rst_fetch_en", {31'b0, fetch_en}, 32'h0);
    checkOutput("rst_flush", {31'b0, flush_if_id}, 32'h0);
    tick();
    tick();
    checkOutput("rst_state", {30'b0, state}, 32'h0);
    checkOutput("rst_count", cycle_count, 32'h0);
    reset = 1'b0;
    quiet();
    checkOutput("rel_next_pc_hold", next_pc, pc_current);
    checkOutput("rel_pc", pc_current, 32'h0);
    checkOutput("rel_fetch_en", {31'b0, fetch_en}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("cmd_cycle_no_fetch", {31'b0, fetch_en}, 32'h0);
    tick();
    quiet();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("run_pc%0d", i), pc_current, 32'(4 * i));
      checkOutput($sformatf("run_fetch%0d", i), {31'b0, fetch_en}, 32'h1);
      tick();
    end
    checkOutput("run_pc4", pc_current, 32'h10);
    checkOutput("run_count", cycle_count, 32'd4);
    checkOutput("run_state", {30'b0, state}, 32'h1);

    // Branch and jump together: branch wins, one flush.
    loadPc(32'h20);
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("br_next_pc", next_pc, 32'h100);
    checkOutput("br_flush", {31'b0, flush_if_id}, 32'h1);
    tick();
    quiet();
    checkOutput("br_pc", pc_current, 32'h100);
    checkOutput("br_flush_once", {31'b0, flush_if_id}, 32'h0);
    checkOutput("br_seq", next_pc, 32'h104);

    // Jump arriving during a 3-cycle stall is parked, then applied.
    loadPc(32'h40);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("st_fetch0", {31'b0, fetch_en}, 32'h0);
    checkOutput("st_hold0", next_pc, 32'h40);
    checkOutput("st_flush0", {31'b0, flush_if_id}, 32'h0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 3; i++) begin
      checkOutput($sformatf("st_pc%0d", i), pc_current, 32'h40);
      checkOutput($sformatf("st_fetch%0d", i), {31'b0, fetch_en}, 32'h0);
      tick();
    end
    quiet();
    checkOutput("st_pc_after", pc_current, 32'h40);
    checkOutput("st_pending_next", next_pc, 32'h80);
    checkOutput("st_pending_flush", {31'b0, flush_if_id}, 32'h1);
    tick();
    checkOutput("st_pc_tgt", pc_current, 32'h80);
    checkOutput("st_flush_once", {31'b0, flush_if_id}, 32'h0);
    checkOutput("st_seq_next", next_pc, 32'h84);
    tick();
    checkOutput("st_pc_seq", pc_current, 32'h84);

    // Single step from IDLE, stretched by a 2-cycle stall.
    reset = 1'b1;
    quiet();
    tick();
    reset = 1'b0;
    loadPc(32'h8);
    checkOutput("sp_idle", {30'b0, state}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("sp_state%0d", i), {30'b0, state}, 32'h2);
      checkOutput($sformatf("sp_hold%0d", i), {31'b0, fetch_en}, 32'h0);
      tick();
    end
    quiet();
    checkOutput("sp_fetch", {31'b0, fetch_en}, 32'h1);
    checkOutput("sp_next", next_pc, 32'hC);
    tick();
    checkOutput("sp_pc", pc_current, 32'hC);
    checkOutput("sp_back_idle", {30'b0, state}, 32'h0);
    checkOutput("sp_count", cycle_count, 32'd1);
    checkOutput("sp_no_more", {31'b0, fetch_en}, 32'h0);
    tick();
    checkOutput("sp_pc_stays", pc_current, 32'hC);

    // Halt in RUN: no advance, commands ignored, reset exits.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    loadPc(32'h30);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("ht_fetch", {31'b0, fetch_en}, 32'h0);
    checkOutput("ht_next", next_pc, 32'h30);
    tick();
    checkOutput("ht_state", {30'b0, state}, 32'h3);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    checkOutput("ht_cmd_ignored", {30'b0, state}, 32'h3);
    checkOutput("ht_pc", pc_current, 32'h30);
    checkOutput("ht_no_fetch", {31'b0, fetch_en}, 32'h0);
    reset = 1'b1;
    quiet();
    checkOutput("ht_rst_next", next_pc, 32'h0);
    tick();
    reset = 1'b0;
    quiet();
    checkOutput("ht_rst_state", {30'b0, state}, 32'h0);
    checkOutput("ht_rst_pc", pc_current, 32'h0);

    // Wrap at the top of the address space, then reset discards a parked redirect.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    loadPc(32'hFFFF_FFFC);
    quiet();
    checkOutput("wr_next", next_pc, 32'h0);
    tick();
    checkOutput("wr_pc", pc_current, 32'h0);
    applyStimulus(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    quiet();
    checkOutput("wr_rst_flush", {31'b0, flush_if_id}, 32'h0);
    tick();
    reset = 1'b0;
    quiet();
    checkOutput("wr_rst_count", cycle_count, 32'h0);
    checkOutput("wr_rst_state", {30'b0, state}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    quiet();
    checkOutput("wr_no_pending", next_pc, 32'h4);
    checkOutput("wr_no_flush", {31'b0, flush_if_id}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the instruction-fetch program counter register. It computes the next-PC value each cycle and drives the register's next-address input, so that register needs no enable or reset of its own.
- Sequences execution in four modes: idle, continuous run, single step and halted, under commands from the debug unit.
- Selects among sequential (+4), branch and jump targets.
- Honours stalls from the hazard unit and holds a redirect that arrives during a stall or hold until it can be applied.

Parameters:
- B, 32, address width.
- RESET_ADDR, 0, address loaded into the PC while reset is asserted.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pc_current  in  B  current PC register output
- branch_taken  in  1  branch redirect request this cycle
- branch_target  in  B  branch destination
- jump_taken  in  1  jump redirect request this cycle
- jump_target  in  B  jump destination
- stall  in  1  hazard unit: hold fetch this cycle
- halt_detected  in  1  decode saw halt instruction
- run_cmd  in  1  debug unit: enter continuous run (1-cycle pulse)
- step_cmd  in  1  debug unit: execute one fetch (1-cycle pulse)
- next_pc  out  B  drives the PC register's next-address input (combinational)
- fetch_en  out  1  PC advances on this edge (advance)
- flush_if_id  out  1  redirect applied this cycle; squash IF/ID
- state  out  2  IDLE=00, RUN=01, STEP=10, HALTED=11
- cycle_count  out  32  number of advances since reset

Behaviour:
- Definitions:
  - advance = (state==RUN or state==STEP) and !stall and !(state==RUN and halt_detected).
  - redirect_now = branch_taken or jump_taken.
  - target_now = branch_target if branch_taken, else jump_target. Branch beats jump because it belongs to the older instruction.
- next_pc priority (combinational), highest first:
  - reset=1: RESET_ADDR, so the PC loads it on the same edge.
  - !advance: pc_current (hold).
  - redirect_now: target_now.
  - pending_valid: pending_target.
  - otherwise pc_current+4, wrapping mod 2^B; carry discarded.
- Pending redirect register (pending_valid, pending_target):
  - Captured when redirect_now=1 and !advance. A newer capture overwrites any older one.
  - Cleared on the first advance cycle; the fresh redirect_now still outranks it that cycle.
  - Cleared by reset.
- flush_if_id = advance and (redirect_now or pending_valid). Asserted for exactly one cycle per applied redirect.
- fetch_en = advance.
- FSM, registered, updated on the rising edge:
  - IDLE: step_cmd → STEP; else run_cmd → RUN; else stay. Both commands together: step wins.
  - RUN: halt_detected → HALTED, with no advance in that cycle; else stay. Commands are ignored.
  - STEP: stay while stall=1. On the advance cycle → IDLE, so exactly one advance per step_cmd.
  - HALTED: hold forever; only reset exits. Commands are ignored.
- cycle_count:
  - Increments by 1 on each advance edge and wraps at 2^32.
  - Cleared to 0 by reset.
- Reset, including mid-run or mid-step:
  - Next state is IDLE, pending_valid=0, cycle_count=0.
  - While reset is held, next_pc=RESET_ADDR, fetch_en=0 and flush_if_id=0.
  - After release: state=00, next_pc=pc_current, fetch_en=0.
- halt_detected is ignored in IDLE and STEP.
- stall in IDLE or HALTED has no effect.
- Latency:
  - From a command pulse to the first advance: 1 cycle (FSM transition edge, then advance on the following edge).
  - A redirect taken while advancing reaches the PC on the same edge.

Test Plan:
- Assert reset for 2 cycles with RESET_ADDR=0, then run_cmd pulse and 4 free cycles → PC sequence 0x0, 0x4, 0x8, 0xC, 0x10; cycle_count=4; state=01.
- In RUN at PC=0x20: assert branch_taken (target 0x100) and jump_taken (target 0x200) together → PC=0x100 next edge; flush_if_id=1 for one cycle.
- In RUN at PC=0x40: stall=1 for 3 cycles with jump_taken (target 0x80) pulsed in the first stalled cycle → PC holds 0x40 with fetch_en=0 for those 3 cycles; after stall drops, PC=0x80 and flush_if_id=1 once; the next advance gives 0x84.
- From IDLE at PC=0x8: step_cmd pulse with stall=1 for 2 cycles → state=10 held while stalled, then exactly one advance to 0xC, back to IDLE; cycle_count +1.
- In RUN: assert halt_detected at PC=0x30 → state=11, PC stays 0x30 indefinitely, run_cmd and step_cmd have no effect; reset → state=00 and PC=RESET_ADDR.
- With B=32 at PC=0xFFFFFFFC in RUN → next PC=0x00000000; then reset mid-run → cycle_count=0 and the pending redirect is discarded.
